alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle fetch/execute controller directly upstream of the 16-bit combinational ALU (operands in_a/in_b, 3-bit sel, 16-bit out; sel 111 = compare returning 0/1/2).
- Fetches 16-bit instructions over a req/ack handshake, reads an internal 8x16 register file, drives the ALU operands and select, captures the ALU result and writes it back.
- Forms the control and datapath core of the small CPU.

Parameters:
- PC_WIDTH, 8, width of program counter and instr_addr.
- RESET_PC, 0, value loaded into pc on reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; sequencer leaves IDLE and keeps fetching while high.
- instr_req  output  1  fetch request.
- instr_addr  output  PC_WIDTH  fetch address (equals pc).
- instr_ack  input  1  memory accepts and returns instr_data this cycle.
- instr_data  input  16  instruction word, valid when instr_ack=1.
- alu_a  output  16  ALU operand A (drives ALU in_a).
- alu_b  output  16  ALU operand B (drives ALU in_b).
- alu_sel  output  3  ALU function (drives ALU sel).
- alu_result  input  16  ALU out, combinational from alu_a/alu_b/alu_sel.
- retired  output  1  one-cycle pulse per written-back instruction.
- busy  output  1  high in every state except IDLE.
- pc  output  PC_WIDTH  current program counter.
- dbg_addr  input  3  register file debug read index.
- dbg_data  output  16  combinational read of reg[dbg_addr].

Behaviour:
- Reset:
  - Asynchronous, any state: state=IDLE, pc=RESET_PC, all 8 registers=0, instruction register=0, wb latch=0.
  - Outputs after reset: instr_req=0, retired=0, busy=0, alu_a/alu_b/alu_sel=0.
  - An in-flight fetch or write-back is abandoned with no register write.
- Instruction format:
  - [15:13] sel, [12] imm, [11:9] rd, [8:6] ra.
  - imm=0: [5:3] rb, [2:0] ignored.
  - imm=1: [5:0] imm6, zero-extended to 16 bits.
- Register 0 always reads 0; writes to rd=0 are discarded (retired still pulses).
- IDLE: instr_req=0. When run=1, next state is FETCH.
- FETCH:
  - instr_req=1, instr_addr=pc.
  - While instr_ack=0: stay in FETCH, instr_req held, pc stable.
  - On instr_ack=1: latch instr_data into the instruction register, pc<=pc+1 (wraps modulo 2^PC_WIDTH), go to EXEC.
  - run is ignored while in FETCH; a started fetch always completes.
- EXEC (exactly 1 cycle):
  - alu_a=reg[ra]; alu_b = imm ? {10'b0, imm6} : reg[rb]; alu_sel=sel.
  - alu_result is latched at the end of the cycle, then go to WB.
  - Outside EXEC, alu_a/alu_b/alu_sel are driven to 0.
- WB (1 cycle):
  - reg[rd]<=latched result (if rd≠0); retired=1 this cycle only.
  - Next state is FETCH if run=1, else IDLE.
- Latency: 3 cycles per instruction when instr_ack is returned in the first FETCH cycle; each ack wait cycle adds 1.
- Hazards: rd written in WB is visible to ra/rb of the next instruction's EXEC; no forwarding is needed.
- dbg_data reflects register contents after the clock edge; a read of index 0 returns 0.
- Widths: all arithmetic is done by the external ALU. The sequencer only truncates and zero-extends as stated above.

Test Plan:
- Reset then run=1 with ack held high: instr_addr sequence is 0,1,2…; retired pulses every 3rd cycle; busy=1 throughout.
- Fetch 16'h1205 (ADDI r1,r0,5), then 16'h1403 (ADDI r2,r0,3) -> alu_b=5 then 3 in EXEC; dbg r1=5, r2=3.
- Then 16'h2650 (SUB r3,r1,r2) -> EXEC shows alu_a=5, alu_b=3, alu_sel=1; r3=2. Then 16'hE850 (CMP r4,r1,r2) -> r4=1.
- 16'h1005 (ADDI r0,r0,5) -> retired pulses, dbg r0 stays 0. Hold instr_ack low for 4 cycles in FETCH -> instr_req stays 1, pc stable, instruction takes 7 cycles.
- Drop run during EXEC -> WB completes, state returns to IDLE, instr_req=0, busy=0. With PC_WIDTH=8 and pc=255, a fetch ack wraps pc to 0.
- Assert rst in WB of a write to r5 -> r5=0, pc=RESET_PC, instr_req=0 immediately without waiting for a clock edge; resumes at RESET_PC once run=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/execute controller in front of a 16-bit combinational ALU.
// It fetches one instruction over req/ack, reads the operands from an 8x16
// register file, drives the ALU for one cycle, then writes the result back.
module alu_sequencer #(
    parameter int unsigned         PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_ack,
    input  logic [15:0]         instr_data,
    output logic [15:0]         alu_a,
    output logic [15:0]         alu_b,
    output logic [2:0]          alu_sel,
    input  logic [15:0]         alu_result,
    output logic                retired,
    output logic                busy,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [2:0]          dbg_addr,
    output logic [15:0]         dbg_data
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExec,
        StWb
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [15:0]         wb_q, wb_d;
    logic [15:0]         regs_q [8];
    logic                reg_we;

    // Instruction fields, decoded from the latched instruction register.
    logic [2:0]  ir_sel;
    logic        ir_imm;
    logic [2:0]  ir_rd;
    logic [2:0]  ir_ra;
    logic [2:0]  ir_rb;
    logic [15:0] op_a;
    logic [15:0] op_b;

    assign ir_sel = ir_q[15:13];
    assign ir_imm = ir_q[12];
    assign ir_rd  = ir_q[11:9];
    assign ir_ra  = ir_q[8:6];
    assign ir_rb  = ir_q[5:3];

    // Register 0 is never written and resets to zero, so it always reads zero.
    assign op_a = regs_q[ir_ra];
    assign op_b = ir_imm ? {10'b0, ir_q[5:0]} : regs_q[ir_rb];

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign busy       = (state_q != StIdle);
    assign dbg_data   = (dbg_addr == 3'd0) ? 16'h0000 : regs_q[dbg_addr];

    // Next-state, fetch handshake, ALU drive and write-back strobe.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wb_d      = wb_q;
        instr_req = 1'b0;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        alu_sel   = 3'b000;
        retired   = 1'b0;
        reg_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // run is not looked at here: a started fetch always completes.
                instr_req = 1'b1;
                if (instr_ack) begin
                    ir_d    = instr_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_a   = op_a;
                alu_b   = op_b;
                alu_sel = ir_sel;
                wb_d    = alu_result;
                state_d = StWb;
            end
            StWb: begin
                retired = 1'b1;
                reg_we  = (ir_rd != 3'd0);
                state_d = run ? StFetch : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state, program counter, instruction register and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            wb_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            wb_q    <= wb_d;
        end
    end

    // Register file write port; a reset during write-back abandons the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (reg_we) begin
            regs_q[ir_rd] <= wb_q;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: instruction memory and ALU models,
// a transaction-level reference model, a per-cycle compare process and
// directed scenarios with literal expectations.
module tb_alu_sequencer;

    localparam int unsigned PW = 8;

    logic          clk;
    logic          rst;
    logic          run;
    logic          ack_en;
    logic          instr_req;
    logic [PW-1:0] instr_addr;
    logic          instr_ack;
    logic [15:0]   instr_data;
    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic [2:0]    alu_sel;
    logic [15:0]   alu_result;
    logic          retired;
    logic          busy;
    logic [PW-1:0] pc;
    logic [2:0]    dbg_addr;
    logic [15:0]   dbg_data;

    logic [15:0] imem [256];
    int checks = 0;
    int errors = 0;
    int cycles = 0;

    // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 compare.
    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[3:0];
            3'd6:    return a >> b[3:0];
            default: return (a == b) ? 16'd0 : ((a > b) ? 16'd1 : 16'd2);
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_sel);
    assign instr_ack  = instr_req & ack_en;
    assign instr_data = imem[instr_addr];

    alu_sequencer #(
        .PC_WIDTH (PW),
        .RESET_PC (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .retired    (retired),
        .busy       (busy),
        .pc         (pc),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycles <= cycles + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_after counts edges since an instruction was accepted: 1 = operands on
    // the ALU, 2 = result being written back, 0 = nothing in flight.
    logic          m_busy;
    logic [1:0]    m_after;
    logic [PW-1:0] m_pc;
    logic [15:0]   m_regs [8];
    logic [15:0]   m_a;
    logic [15:0]   m_b;
    logic [15:0]   m_res;
    logic [2:0]    m_sel;
    logic [2:0]    m_rd;

    function automatic logic [15:0] reg_rd(input logic [2:0] i);
        return (i == 3'd0) ? 16'h0000 : m_regs[i];
    endfunction

    function automatic logic [15:0] opb(input logic [15:0] w);
        return w[12] ? {10'b0, w[5:0]} : reg_rd(w[5:3]);
    endfunction

    // Model advances one transaction step per clock from run/ack_en alone.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_after <= 2'd0;
            m_pc    <= 8'h00;
            m_a     <= 16'h0;
            m_b     <= 16'h0;
            m_res   <= 16'h0;
            m_sel   <= 3'd0;
            m_rd    <= 3'd0;
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0;
        end else if (m_after == 2'd2) begin
            if (m_rd != 3'd0) m_regs[m_rd] <= m_res;
            m_after <= 2'd0;
            m_busy  <= run;
        end else if (m_after == 2'd1) begin
            m_after <= 2'd2;
        end else if (m_busy) begin
            if (ack_en) begin
                m_sel   <= imem[m_pc][15:13];
                m_rd    <= imem[m_pc][11:9];
                m_a     <= reg_rd(imem[m_pc][8:6]);
                m_b     <= opb(imem[m_pc]);
                m_res   <= alu_fn(reg_rd(imem[m_pc][8:6]), opb(imem[m_pc]), imem[m_pc][15:13]);
                m_pc    <= m_pc + PW'(1);
                m_after <= 2'd1;
            end
        end else if (run) begin
            m_busy <= 1'b1;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        chk("instr_req", 32'(instr_req), 32'(m_busy && (m_after == 2'd0)));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("retired", 32'(retired), 32'(m_after == 2'd2));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr_addr", 32'(instr_addr), 32'(m_pc));
        chk("alu_a", 32'(alu_a), (m_after == 2'd1) ? 32'(m_a) : 32'd0);
        chk("alu_b", 32'(alu_b), (m_after == 2'd1) ? 32'(m_b) : 32'd0);
        chk("alu_sel", 32'(alu_sel), (m_after == 2'd1) ? 32'(m_sel) : 32'd0);
        chk("dbg_data", 32'(dbg_data), 32'(reg_rd(dbg_addr)));
    end

    // ---------------- stimulus ----------------
    task automatic nclk();
        #1 dbg_addr = dbg_addr + 3'd1;
        @(negedge clk);
    endtask

    task automatic wait_exec(input string what);
        int n = 0;
        do begin
            nclk();
            n++;
        end while (m_after != 2'd1 && n < 40);
        chk({what, " reached"}, 32'(m_after == 2'd1), 32'd1);
    endtask

    task automatic dbg_chk(input string name, input logic [2:0] idx, input logic [15:0] exp);
        dbg_addr = idx;
        #1 chk(name, 32'(dbg_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        for (int i = 0; i < 256; i++) imem[i] = 16'h1D81;  // ADDI r6,r6,1
        imem[0]   = 16'h1205;  // ADDI r1,r0,5
        imem[1]   = 16'h1403;  // ADDI r2,r0,3
        imem[2]   = 16'h2650;  // SUB  r3,r1,r2
        imem[3]   = 16'hE850;  // CMP  r4,r1,r2
        imem[4]   = 16'h1005;  // ADDI r0,r0,5
        imem[255] = 16'h1A07;  // ADDI r5,r0,7
        rst = 1'b0; run = 1'b0; ack_en = 1'b1; dbg_addr = 3'd0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst instr_req", 32'(instr_req), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst retired", 32'(retired), 32'd0);
        chk("rst alu_sel", 32'(alu_sel), 32'd0);
        chk("rst pc", 32'(pc), 32'd0);
        rst = 1'b0;
        run = 1'b1;

        wait_exec("exec 1205");
        chk("1205 alu_a", 32'(alu_a), 32'd0);
        chk("1205 alu_b", 32'(alu_b), 32'd5);
        chk("1205 pc", 32'(pc), 32'd1);
        wait_exec("exec 1403");
        chk("1403 alu_b", 32'(alu_b), 32'd3);
        wait_exec("exec 2650");
        chk("sub alu_a", 32'(alu_a), 32'd5);
        chk("sub alu_b", 32'(alu_b), 32'd3);
        chk("sub alu_sel", 32'(alu_sel), 32'd1);
        wait_exec("exec E850");
        chk("cmp alu_sel", 32'(alu_sel), 32'd7);
        dbg_chk("dbg r1", 3'd1, 16'd5);
        dbg_chk("dbg r2", 3'd2, 16'd3);
        dbg_chk("dbg r3", 3'd3, 16'd2);
        wait_exec("exec 1005");
        chk("r0 write alu_b", 32'(alu_b), 32'd5);
        dbg_chk("dbg r4", 3'd4, 16'd1);
        chk("model r3", 32'(m_regs[3]), 32'd2);
        ack_en = 1'b0;

        // Four fetch cycles with ack held low.
        nclk();
        chk("r0 write retired", 32'(retired), 32'd1);
        t0 = cycles;
        for (int k = 0; k < 4; k++) begin
            nclk();
            chk("stall instr_req", 32'(instr_req), 32'd1);
            chk("stall pc", 32'(pc), 32'd5);
        end
        dbg_chk("dbg r0", 3'd0, 16'd0);
        nclk();
        ack_en = 1'b1;
        n = 0;
        do begin
            nclk();
            n++;
        end while (!retired && n < 20);
        chk("stalled instr cycles", 32'(cycles - t0), 32'd7);

        // Drop run during EXEC: write-back completes, then idle.
        wait_exec("exec addr6");
        chk("addr6 alu_a", 32'(alu_a), 32'd1);
        run = 1'b0;
        nclk();
        chk("drop retired", 32'(retired), 32'd1);
        nclk();
        chk("idle busy", 32'(busy), 32'd0);
        chk("idle instr_req", 32'(instr_req), 32'd0);
        chk("idle pc", 32'(pc), 32'd7);
        nclk();
        nclk();
        chk("still idle", 32'(busy), 32'd0);
        dbg_chk("dbg r6", 3'd6, 16'd2);

        // Run through to address 255 and check the pc wrap.
        run = 1'b1;
        n = 0;
        do begin
            nclk();
            n++;
        end while (!(m_busy && m_after == 2'd0 && m_pc == 8'd255) && n < 1000);
        chk("reached addr 255", 32'(instr_addr), 32'd255);
        wait_exec("exec addr255");
        chk("wrap pc", 32'(pc), 32'd0);
        chk("r5 alu_b", 32'(alu_b), 32'd7);

        // Reset during write-back of r5.
        nclk();
        chk("r5 retired", 32'(retired), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async instr_req", 32'(instr_req), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async retired", 32'(retired), 32'd0);
        chk("async pc", 32'(pc), 32'd0);
        dbg_chk("dbg r5 after rst", 3'd5, 16'd0);
        dbg_chk("dbg r1 after rst", 3'd1, 16'd0);
        nclk();
        #1 rst = 1'b0;
        nclk();
        chk("resume instr_req", 32'(instr_req), 32'd1);
        chk("resume addr", 32'(instr_addr), 32'd0);
        wait_exec("exec after rst");
        chk("resume alu_b", 32'(alu_b), 32'd5);
        nclk();
        nclk();
        dbg_chk("dbg r1 again", 3'd1, 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
